// File: rtl/fp32_add_sub.sv
// IEEE-754 single-precision add/subtract, round-toward-zero, flush-to-zero inputs.
// Latency 1 cycle, one op per cycle, no backpressure (out_valid follows in_valid).
module fp32_add_sub (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        add_bar_sub,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        exception
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        a_sgn, b_sgn;
    logic [7:0]  a_exp, b_exp;
    logic        a_special, b_special, a_nan, b_nan;
    logic [30:0] a_mag, b_mag;
    logic        swap;
    logic        l_sgn, s_sgn;
    logic [30:0] l_mag, s_mag;
    logic [7:0]  l_exp, s_exp, shift;
    logic [23:0] l_man, s_man, s_man_sh;
    logic [24:0] sum;
    logic [23:0] diff;
    logic [4:0]  lzc;
    logic [23:0] n_man;
    logic signed [9:0] n_exp;

    logic        out_valid_q;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;

    assign a_sgn     = a_operand[31];
    assign b_sgn     = b_operand[31] ^ add_bar_sub;
    assign a_exp     = a_operand[30:23];
    assign b_exp     = b_operand[30:23];
    assign a_special = (a_exp == 8'hFF);
    assign b_special = (b_exp == 8'hFF);
    assign a_nan     = a_special && (a_operand[22:0] != 23'd0);
    assign b_nan     = b_special && (b_operand[22:0] != 23'd0);

    // Zero exponent flushes the whole magnitude so denormals order as zero.
    assign a_mag = (a_exp == 8'd0) ? 31'd0 : a_operand[30:0];
    assign b_mag = (b_exp == 8'd0) ? 31'd0 : b_operand[30:0];

    assign swap  = (b_mag > a_mag);
    assign l_sgn = swap ? b_sgn : a_sgn;
    assign s_sgn = swap ? a_sgn : b_sgn;
    assign l_mag = swap ? b_mag : a_mag;
    assign s_mag = swap ? a_mag : b_mag;

    assign l_exp = l_mag[30:23];
    assign s_exp = s_mag[30:23];
    assign l_man = (l_exp != 8'd0) ? {1'b1, l_mag[22:0]} : 24'd0;
    assign s_man = (s_exp != 8'd0) ? {1'b1, s_mag[22:0]} : 24'd0;
    assign shift = l_exp - s_exp;

    assign s_man_sh = (shift >= 8'd25) ? 24'd0 : (s_man >> shift);
    assign sum      = {1'b0, l_man} + {1'b0, s_man_sh};
    assign diff     = l_man - s_man_sh;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        lzc = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (diff[i]) lzc = 5'(23 - i);
        end
    end

    always_comb begin
        n_man = 24'd0;
        n_exp = 10'sd0;
        if (l_sgn == s_sgn) begin
            if (sum[24]) begin
                n_man = sum[24:1];
                n_exp = $signed({2'b00, l_exp}) + 10'sd1;
            end else begin
                n_man = sum[23:0];
                n_exp = $signed({2'b00, l_exp});
            end
        end else begin
            n_man = diff << lzc;
            n_exp = $signed({2'b00, l_exp}) - $signed({5'b00000, lzc});
        end
    end

    always_comb begin
        result_d = 32'd0;
        exc_d    = 1'b0;
        if (a_special || b_special) begin
            exc_d = 1'b1;
            if (a_nan || b_nan || (a_special && b_special && (a_sgn != b_sgn)))
                result_d = QNAN;
            else
                result_d = {(a_special ? a_sgn : b_sgn), 8'hFF, 23'd0};
        end else if ((n_man == 24'd0) || (n_exp <= 10'sd0)) begin
            result_d = 32'd0;
        end else if (n_exp >= 10'sd255) begin
            result_d = {l_sgn, 8'hFF, 23'd0};
            exc_d    = 1'b1;
        end else begin
            result_d = {l_sgn, n_exp[7:0], n_man[22:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            exc_q       <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                exc_q    <= exc_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign exception = exc_q;
endmodule

// File: tb/tb_fp32_add_sub.sv
// Scoreboard bench for fp32_add_sub: directed vectors with hand-computed results.
module tb_fp32_add_sub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a_operand, b_operand;
    logic        add_bar_sub;
    logic        out_valid;
    logic [31:0] result;
    logic        exception;

    fp32_add_sub dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a_operand(a_operand), .b_operand(b_operand), .add_bar_sub(add_bar_sub),
        .out_valid(out_valid), .result(result), .exception(exception)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        x;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   op_id   = 0;
    int   vld_cnt = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] r, input logic x);
        exp_t e;
        @(negedge clk);
        a_operand   = a;
        b_operand   = b;
        add_bar_sub = sub;
        in_valid    = 1'b1;
        e.r = r; e.x = x; e.id = op_id;
        sb_q.push_back(e);
        op_id++;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (sb_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check32("scoreboard drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: compares every presented output against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                vld_cnt++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected out_valid: got result %h with empty scoreboard", result);
                end else begin
                    e = sb_q.pop_front();
                    check32($sformatf("op%0d result", e.id), result, e.r);
                    check32($sformatf("op%0d exception", e.id), {31'd0, exception}, {31'd0, e.x});
                end
            end
        end
    end

    localparam int NV = 16;
    logic [31:0] va [NV] = '{32'h415EB852, 32'h40DEB852, 32'h40400000, 32'h40490FDB,
                             32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'hFF800000,
                             32'h3F000000, 32'h3F800000, 32'h80000000, 32'h00000001,
                             32'h00C00000, 32'h3F800000, 32'h7FC00000, 32'h3F800000};
    logic [31:0] vb [NV] = '{32'h40DEB852, 32'h415EB852, 32'h3F800000, 32'h40490FDB,
                             32'h30800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
                             32'h3E800000, 32'h40400000, 32'h80000000, 32'h3F800000,
                             32'h00800000, 32'h34000000, 32'h3F800000, 32'h7F800000};
    logic        vs [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] vr [NV] = '{32'h41A70A3D, 32'h41A70A3D, 32'h40000000, 32'h00000000,
                             32'h3F800000, 32'h7F800000, 32'h7FC00000, 32'hFF800000,
                             32'h3F400000, 32'hC0000000, 32'h00000000, 32'h3F800000,
                             32'h00000000, 32'h3F7FFFFE, 32'h7FC00000, 32'hFF800000};
    logic        vx [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a_operand   = 32'd0;
        b_operand   = 32'd0;
        add_bar_sub = 1'b0;
        #12;
        check32("reset out_valid", {31'd0, out_valid}, 32'd0);
        check32("reset result", result, 32'd0);
        check32("reset exception", {31'd0, exception}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op: out_valid exactly one cycle after sampling, then result holds.
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
        @(posedge clk);
        #2;
        check32("latency out_valid high", {31'd0, out_valid}, 32'd1);
        idle();
        @(posedge clk);
        #2;
        check32("out_valid drops", {31'd0, out_valid}, 32'd0);
        check32("result holds", result, 32'h40000000);

        for (int i = 0; i < NV; i++) issue(va[i], vb[i], vs[i], vr[i], vx[i]);
        idle();
        drain();

        // Four back-to-back ops: exactly four valid cycles.
        repeat (2) @(negedge clk);
        vld_cnt = 0;
        issue(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 1'b0);
        issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0);
        issue(32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 1'b0);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1);
        idle();
        repeat (4) @(posedge clk);
        #2;
        check32("stream valid cycles", 32'(vld_cnt), 32'd4);
        drain();

        // Reset asserted between edges with an op pending on the inputs.
        issue(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 1'b0);
        @(posedge clk);
        #3;
        a_operand = 32'h40400000;
        b_operand = 32'h3F800000;
        add_bar_sub = 1'b0;
        rst_n = 1'b0;
        #1;
        check32("async reset out_valid", {31'd0, out_valid}, 32'd0);
        check32("async reset result", result, 32'd0);
        check32("async reset exception", {31'd0, exception}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            check32($sformatf("post-reset idle %0d", k), {31'd0, out_valid}, 32'd0);
        end
        issue(32'h415EB852, 32'h40DEB852, 1'b0, 32'h41A70A3D, 1'b0);
        idle();
        drain();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
